// File: rtl/pe_operand_loader.sv
// pe_operand_loader: streams bias, weights and inputs into registered PE operand vectors and captures the PE result.
// Define WEIGHT_REUSE_EN to let 'reuse' keep bias and weights for the next neuron.
module pe_operand_loader #(
    parameter int N_TAPS = 62,
    parameter int DW     = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [DW-1:0]      s_data,
    input  logic               reuse,
    output logic [DW-1:0]      pe_bias,
    output logic [N_TAPS*DW-1:0] pe_weight,
    output logic [N_TAPS*DW-1:0] pe_in,
    input  logic [DW-1:0]      pe_out,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [DW-1:0]      res_data
);
    localparam int CW = N_TAPS > 1 ? $clog2(N_TAPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(N_TAPS - 1);

    typedef enum logic [2:0] {LOAD_BIAS, LOAD_WEIGHT, LOAD_IN, EVAL, RESULT} state_t;

    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic last, reuse_hit;

`ifdef WEIGHT_REUSE_EN
    assign reuse_hit = reuse;
`else
    logic unused_reuse;
    assign unused_reuse = reuse;
    assign reuse_hit = 1'b0;
`endif

    assign s_ready = state inside {LOAD_BIAS, LOAD_WEIGHT, LOAD_IN};
    assign last = cnt == LAST;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= LOAD_BIAS;
        else state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            LOAD_BIAS:   state_n = s_valid ? LOAD_WEIGHT : LOAD_BIAS;
            LOAD_WEIGHT: state_n = s_valid && last ? LOAD_IN : LOAD_WEIGHT;
            LOAD_IN:     state_n = s_valid && last ? EVAL : LOAD_IN;
            EVAL:        state_n = RESULT;
            RESULT:      state_n = res_ready ? (reuse_hit ? LOAD_IN : LOAD_BIAS) : RESULT;
            default:     state_n = LOAD_BIAS;
        endcase
    end

    // In the LOAD states s_ready is high, so s_valid alone marks an accepted byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            pe_bias   <= '0;
            pe_weight <= '0;
            pe_in     <= '0;
            res_data  <= '0;
            res_valid <= 1'b0;
        end else begin
            if (s_valid && state == LOAD_BIAS) pe_bias <= s_data;
            if (s_valid && state == LOAD_WEIGHT) pe_weight[32'(cnt)*DW +: DW] <= s_data;
            if (s_valid && state == LOAD_IN) pe_in[32'(cnt)*DW +: DW] <= s_data;
            if (s_valid && (state == LOAD_WEIGHT || state == LOAD_IN)) cnt <= last ? '0 : cnt + CW'(1);
            if (state == EVAL) begin
                res_data  <= pe_out;
                res_valid <= 1'b1;
            end else if (state == RESULT && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pe_operand_loader.sv
// tb_pe_operand_loader: randomized self-checking bench with a byte-array model of the loaded neuron and a toy PE.
module tb_pe_operand_loader;
    localparam int N = 62;
    localparam int W = N * 8;

    logic clk = 0, rst_n = 1, s_valid = 0, reuse = 0, res_ready = 0;
    logic [7:0] s_data = 0;
    logic s_ready, res_valid;
    logic [7:0] pe_bias, pe_out, res_data;
    logic [W-1:0] pe_weight, pe_in;

    int checks = 0, failures = 0;
    logic [7:0] mb;
    logic [7:0] mw[N];
    logic [7:0] mi[N];
    bit full;

    always #5 clk = ~clk;

    pe_operand_loader #(.N_TAPS(N), .DW(8)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .reuse(reuse), .pe_bias(pe_bias), .pe_weight(pe_weight), .pe_in(pe_in),
        .pe_out(pe_out), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
    );

    // Toy PE: bias plus the byte-wise XOR of weights and inputs, modulo 256.
    always_comb begin
        pe_out = pe_bias;
        for (int k = 0; k < N; k++) pe_out = pe_out + (pe_weight[k*8 +: 8] ^ pe_in[k*8 +: 8]);
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] pack(input logic [7:0] a[N]);
        logic [W-1:0] r;
        for (int k = 0; k < N; k++) r[k*8 +: 8] = a[k];
        return r;
    endfunction

    function automatic logic [7:0] ref_out();
        logic [7:0] r = mb;
        for (int k = 0; k < N; k++) r = r + (mw[k] ^ mi[k]);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_buses(input string tag);
        check({tag, "_bias"}, 512'(pe_bias), 512'(mb));
        check({tag, "_weight"}, 512'(pe_weight), 512'(pack(mw)));
        check({tag, "_in"}, 512'(pe_in), 512'(pack(mi)));
    endtask

    task automatic zero_model();
        mb = 0;
        for (int k = 0; k < N; k++) begin
            mw[k] = 0;
            mi[k] = 0;
        end
    endtask

    // stall: 0 none, 1 exactly one idle cycle per byte, 2 random 0..3 idle cycles
    task automatic send_byte(input logic [7:0] b, input int stall);
        int idle;
        idle = stall == 0 ? 0 : stall == 1 ? 1 : int'($urandom_range(0, 3));
        s_valid = 0;
        for (int i = 0; i < idle; i++) begin
            s_data = 8'($urandom);
            check("stall_ready", 512'(s_ready), 512'(1));
            tick();
        end
        s_data = b;
        s_valid = 1;
        check("load_ready", 512'(s_ready), 512'(1));
        tick();
        s_valid = 0;
    endtask

    task automatic run_neuron(input int stall, input int hold, input bit rz);
        logic [7:0] exp;
        if (full) begin
            send_byte(mb, stall);
            for (int k = 0; k < N; k++) send_byte(mw[k], stall);
        end
        for (int k = 0; k < N; k++) send_byte(mi[k], stall);
        exp = ref_out();
        check("eval_ready", 512'(s_ready), 512'(0));
        check("eval_valid", 512'(res_valid), 512'(0));
        s_valid = 1;
        s_data = 8'($urandom);
        tick();
        check("res_valid", 512'(res_valid), 512'(1));
        check("res_data", 512'(res_data), 512'(exp));
        check_buses("eval");
        for (int i = 0; i < hold; i++) begin
            s_valid = 1'($urandom);
            s_data = 8'($urandom);
            tick();
            check("hold_valid", 512'(res_valid), 512'(1));
            check("hold_data", 512'(res_data), 512'(exp));
            check("hold_ready", 512'(s_ready), 512'(0));
        end
        s_valid = 0;
        res_ready = 1;
        reuse = rz;
        tick();
        res_ready = 0;
        reuse = 0;
        check("clr_valid", 512'(res_valid), 512'(0));
        check("post_ready", 512'(s_ready), 512'(1));
        check_buses("post");
`ifdef WEIGHT_REUSE_EN
        full = !rz;
`else
        full = 1;
`endif
    endtask

    initial begin
        #1 rst_n = 0;
        #1;
        zero_model();
        check("rst_valid", 512'(res_valid), 512'(0));
        check("rst_data", 512'(res_data), 512'(0));
        check("rst_ready", 512'(s_ready), 512'(1));
        check_buses("rst");
        @(negedge clk) rst_n = 1;
        tick();
        full = 1;

        mb = 8'h85;
        for (int k = 0; k < N; k++) begin
            mw[k] = 8'(k);
            mi[k] = 8'h80 | 8'(k);
        end
        run_neuron(0, 0, 0);
        check("w0", 512'(pe_weight[7:0]), 512'(8'h00));
        check("w61", 512'(pe_weight[495:488]), 512'(8'h3D));
        check("i61", 512'(pe_in[495:488]), 512'(8'hBD));
        check("bias85", 512'(pe_bias), 512'(8'h85));

        run_neuron(1, 10, 0);

        mb = 8'($urandom);
        for (int k = 0; k < N; k++) mw[k] = 8'($urandom);
        send_byte(mb, 0);
        for (int k = 0; k <= 30; k++) send_byte(mw[k], 0);
        #2 rst_n = 0;
        #1;
        zero_model();
        check("midrst_valid", 512'(res_valid), 512'(0));
        check("midrst_data", 512'(res_data), 512'(0));
        check_buses("midrst");
        @(negedge clk) rst_n = 1;
        tick();
        full = 1;
        mb = 8'h01;
        for (int k = 0; k < N; k++) begin
            mw[k] = 8'($urandom);
            mi[k] = 8'($urandom);
        end
        run_neuron(2, 3, 0);

        for (int n = 0; n < 6; n++) begin
            if (n == 0) begin
                res_ready = 1;
                tick();
                tick();
                check("early_ready", 512'(res_valid), 512'(0));
                res_ready = 0;
            end
            if (full) begin
                mb = 8'($urandom);
                for (int k = 0; k < N; k++) mw[k] = 8'($urandom);
            end
            for (int k = 0; k < N; k++) mi[k] = n == 1 ? 8'h11 : 8'($urandom);
            run_neuron(2, int'($urandom_range(0, 4)), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pe_operand_loader.md
PE_OPERAND_LOADER -- requirements
Module: pe_operand_loader

Interface
REQ-001 SHALL have parameter N_TAPS, default 62, giving the number of weight/input bytes per neuron.
REQ-002 SHALL have parameter DW, default 8, giving the sign-magnitude byte width (bit DW-1 = sign).
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 s_valid  input  1  serial operand byte valid.
REQ-007 s_ready  output  1  loader accepts s_data this cycle.
REQ-008 s_data  input  DW  operand byte; order per neuron: bias, N_TAPS weights, N_TAPS inputs.
REQ-009 reuse  input  1  request to keep bias and weights for the next neuron.
REQ-010 pe_bias  output  DW  registered bias to the PE.
REQ-011 pe_weight  output  N_TAPS*DW  registered weight vector to the PE.
REQ-012 pe_in  output  N_TAPS*DW  registered input vector to the PE.
REQ-013 pe_out  input  DW  PE activation result (combinational from pe_*).
REQ-014 res_valid  output  1  captured result valid.
REQ-015 res_ready  input  1  result consumer ready.
REQ-016 res_data  output  DW  captured PE result.

Function
REQ-017 SHALL implement states LOAD_BIAS, LOAD_WEIGHT, LOAD_IN, EVAL, RESULT.
REQ-018 A byte is accepted on a rising edge with s_valid and s_ready both high; s_ready SHALL be high exactly in the three LOAD states.
REQ-019 LOAD_BIAS: accepted byte -> pe_bias; go to LOAD_WEIGHT.
REQ-020 LOAD_WEIGHT: k-th accepted byte (k = 0..N_TAPS-1) -> pe_weight[k*DW +: DW]; after k = N_TAPS-1 go to LOAD_IN.
REQ-021 LOAD_IN: k-th accepted byte -> pe_in[k*DW +: DW]; after k = N_TAPS-1 go to EVAL.
REQ-022 Byte counter SHALL be ceil(log2(N_TAPS)) bits, advance only on acceptance, and wrap N_TAPS-1 -> 0 on each LOAD_WEIGHT/LOAD_IN exit.
REQ-023 s_valid low in a LOAD state: no state, counter or vector change.
REQ-024 EVAL lasts exactly one cycle; at its closing edge pe_out SHALL be registered into res_data, res_valid set, state -> RESULT (res_valid high in the cycle after the last input byte is accepted).
REQ-025 pe_bias, pe_weight, pe_in SHALL stay stable from EVAL until the next LOAD byte is accepted.
REQ-026 RESULT: res_valid and res_data held until res_valid && res_ready at an edge; then res_valid clears and state -> LOAD_BIAS (or LOAD_IN per REQ-031).
REQ-027 res_ready high before res_valid SHALL have no effect; s_valid during EVAL/RESULT SHALL be ignored (s_ready low).
REQ-028 Vectors are not cleared between neurons; each byte overwrites its slot.

Reset
REQ-029 rst_n low SHALL immediately force state LOAD_BIAS, counter 0, pe_bias 0, pe_weight 0, pe_in 0, res_data 0, res_valid 0; s_ready reads 1 once rst_n is high.
REQ-030 Reset mid-load or in RESULT SHALL discard the partial neuron/pending result; next accepted byte is a bias.

Configuration
REQ-031 With WEIGHT_REUSE_EN defined: if reuse is high at the result-handshake edge, next state SHALL be LOAD_IN with pe_bias/pe_weight retained; else LOAD_BIAS.
REQ-032 Without WEIGHT_REUSE_EN: reuse port SHALL exist but be ignored; RESULT always -> LOAD_BIAS.

Verification
REQ-033 Load bias 0x85, weight k = k, input k = 0x80|k, no stalls -> pe_bias 0x85, pe_weight[7:0] 0x00, pe_weight[495:488] 0x3D, pe_in[495:488] 0xBD; pe_out driven 0x2A -> res_data 0x2A, res_valid high one cycle after the 125th byte.
REQ-034 Same stream with s_valid toggling every other cycle -> identical buses/result; s_ready never low in LOAD states.
REQ-035 Hold res_ready low 10 cycles -> res_valid and res_data stable, s_ready low; raise res_ready -> s_ready high next cycle.
REQ-036 Assert rst_n low after weight byte 30 -> all outputs 0; next stream (bias 0x01...) loads from bias slot.
REQ-037 WEIGHT_REUSE_EN defined, reuse high at handshake, send 62 bytes 0x11 -> pe_in all 0x11, pe_bias/pe_weight unchanged, result after 62 bytes; undefined -> first byte lands in pe_bias.
